// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and its helpers.
// Provides the loader state encoding and the image header length width.
// No logic; pure types and constants.
package imem_loader_pkg;

  // Width of the word-count header that prefixes every program image.
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_WORD   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a byte stream MSB-first into 32-bit words (byte0 -> [31:24]).
// Latency: word/word_ready are combinational on the 4th shifted byte.
// Backpressure: none internally; the caller gates shift_en with its handshake.
//
// Ports: clk, rst (async active-low), clr (restart count), shift_en (byte
// accepted this cycle), byte_data; word = assembled word including the byte
// being shifted now, word_ready = this shift completes a word.
module byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      shreg    <= {shreg[15:0], byte_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Exposing the word including the incoming byte lets the caller register
  // the full word on the same edge that accepts its last byte.
  assign word       = {shreg, byte_data};
  assign word_ready = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> consecutive imem word writes.
// Latency: write strobe one cycle after the edge accepting a word's 4th byte.
// Backpressure: byte_ready low outside header/word states and during WRITE.
//
// Ports: clk, rst (async active-low), start pulse; byte_valid/byte_ready/
// byte_data stream in; wr_en/wr_addr (byte address)/wr_data to imem;
// busy/done/error status; cpu_rst_n holds the pipeline in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

  // One extra bit so an image of exactly 2^ADDR_W words counts to N cleanly.
  localparam int          IDX_W   = ADDR_W + 1;
  localparam logic [31:0] MAX_W32 = MAX_WORDS;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_next;
  logic [IDX_W-1:0]   word_idx;
  logic [IDX_W-1:0]   idx_inc;
  logic               accept;
  logic               asm_shift;
  logic               asm_clr;
  logic [31:0]        asm_word;
  logic               asm_ready;

  assign byte_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_WORD);
  assign accept     = byte_valid && byte_ready;
  assign len_next   = {len_q[15:8], byte_data};
  assign idx_inc    = word_idx + 1'b1;

  assign busy      = byte_ready || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERROR);
  assign cpu_rst_n = (state_q == ST_DONE);

  // Clearing while the low length byte is pending guarantees every image
  // starts word assembly from byte 0, even after an aborted or error load.
  assign asm_clr   = (state_q == ST_LEN_LO);
  assign asm_shift = accept && (state_q == ST_WORD);

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .shift_en   (asm_shift),
    .byte_data  (byte_data),
    .word       (asm_word),
    .word_ready (asm_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          if (len_next == '0)                    state_d = ST_DONE;
          else if (32'(len_next) > MAX_W32)      state_d = ST_ERROR;
          else                                   state_d = ST_WORD;
        end
      end
      ST_WORD: begin
        if (asm_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (32'(idx_inc) == 32'(len_q)) state_d = ST_DONE;
        else                            state_d = ST_WORD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      word_idx <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (accept && state_q == ST_LEN_HI) len_q[15:8] <= byte_data;
      if (accept && state_q == ST_LEN_LO) begin
        len_q[7:0] <= byte_data;
        word_idx   <= '0;
      end
      // Address, data and strobe are captured together so they line up
      // in the WRITE cycle.
      if (state_q == ST_WORD && asm_ready) begin
        wr_en   <= 1'b1;
        wr_addr <= 32'({word_idx, 2'b00});
        wr_data <= asm_word;
      end
      if (state_q == ST_WRITE) word_idx <= idx_inc;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  logic [63:0] exp_q[$];   // {addr, data}
  logic [31:0] img[$];

  imem_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_rst_n  (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (wr_en) begin
      logic [63:0] e;
      wr_count++;
      check("ready_in_write", {31'd0, byte_ready}, 32'd0);
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_write observed=%h/%h expected=none", wr_addr, wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end

  // Called and returns at a negedge; byte transfers at the posedge in between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("byte_timeout", n, (n < 64) ? n : 0);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n, input int gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
  endtask

  // Sends img[] and, if asked, pushes the writes it should produce.
  task automatic send_words(input int gap, input bit push);
    logic [31:0] w;
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      if (push) exp_q.push_back({32'(i * 4), w});
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_settled(input string tag);
    int n;
    n = 0;
    while (!(done || error) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (n < 20)}, 32'd1);
  endtask

  initial begin
    int base;
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    check("rst_byte_ready", {31'd0, byte_ready}, 0);
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", {31'd0, busy}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    check("idle_byte_ready", {31'd0, byte_ready}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_done", {31'd0, done}, 0);
    check("idle_writes", wr_count, 0);

    // Two-word image, byte_valid held high
    pulse_start();
    check("load_busy", {31'd0, busy}, 1);
    check("load_ready", {31'd0, byte_ready}, 1);
    img = '{32'h2008_0005, 32'h8C09_0004};
    base = wr_count;
    send_header(16'd2, 0);
    send_words(0, 1'b1);
    wait_settled("settle_1");
    check("l1_done", {31'd0, done}, 1);
    check("l1_cpu_rst_n", {31'd0, cpu_rst_n}, 1);
    check("l1_busy", {31'd0, busy}, 0);
    check("l1_writes", wr_count - base, 2);

    // Same image, byte_valid toggling; a start mid-load must be ignored
    pulse_start();
    check("reload_done", {31'd0, done}, 0);
    check("reload_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    base = wr_count;
    send_header(16'd2, 1);
    pulse_start();
    check("busy_start_ignored", {31'd0, busy}, 1);
    send_words(1, 1'b1);
    wait_settled("settle_2");
    check("l2_done", {31'd0, done}, 1);
    check("l2_writes", wr_count - base, 2);

    // Empty image goes straight to DONE
    pulse_start();
    base = wr_count;
    send_header(16'd0, 0);
    check("empty_done", {31'd0, done}, 1);
    check("empty_cpu_rst_n", {31'd0, cpu_rst_n}, 1);
    repeat (2) @(negedge clk);
    check("empty_writes", wr_count - base, 0);

    // Oversized image (MAX_WORDS=4) is rejected; error is sticky
    pulse_start();
    base = wr_count;
    send_header(16'd5, 0);
    check("err_error", {31'd0, error}, 1);
    check("err_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    check("err_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, error}, 1);
    check("err_ready", {31'd0, byte_ready}, 0);
    check("err_writes", wr_count - base, 0);
    pulse_start();
    check("err_cleared", {31'd0, error}, 0);
    img = '{32'hDEAD_BEEF};
    send_header(16'd1, 0);
    send_words(0, 1'b1);
    wait_settled("settle_3");
    check("recover_done", {31'd0, done}, 1);
    check("recover_error", {31'd0, error}, 0);

    // Exactly MAX_WORDS is accepted
    pulse_start();
    base = wr_count;
    img = '{32'h0102_0304, 32'h1122_3344, 32'hA5A5_5A5A, 32'hFFFF_0000};
    send_header(16'd4, 0);
    send_words(0, 1'b1);
    wait_settled("settle_4");
    check("max_done", {31'd0, done}, 1);
    check("max_error", {31'd0, error}, 0);
    check("max_writes", wr_count - base, 4);

    // Reset in the middle of a word: nothing written from the aborted load
    pulse_start();
    base = wr_count;
    send_header(16'd1, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_ready", {31'd0, byte_ready}, 0);
    check("abort_cpu_rst_n", {31'd0, cpu_rst_n}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    img = '{32'h0000_0000};
    send_header(16'd1, 0);
    send_words(0, 1'b1);
    wait_settled("settle_5");
    check("abort_done", {31'd0, done}, 1);
    check("abort_writes", wr_count - base, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so a stuck design still reports.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
